alu_src_ctrl_fsm: RTL

Multicycle control sequencer that drives the select lines of the ALU operand muxes (source B: 00 Reg_B, 01 constant 4, 10 sign_extend, 11 sign_extend<<2), plus the ALU opcode and datapath write enables. It sits opposite the operand muxes: it decodes opcode/funct from the instruction register and steps fetch/decode/execute states. It supports R-type add/sub/and, addi, lw, sw, beq and j.

---
 rtl/alu_src_ctrl_fsm_pkg.sv | 73 +++++++
 rtl/alu_src_ctrl_fsm_alu_funct_decode.sv | 22 ++
 rtl/alu_src_ctrl_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_src_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle ALU source sequencer: states, mux codes, opcodes.
// No logic, no latency, no flow control. ALU_CTRL_TRAP_EN adds the TRAP state.
package alu_src_ctrl_fsm_pkg;

  typedef enum logic [4:0] {
    S_RST      = 5'd0,
    S_FETCH0   = 5'd1,
    S_FETCHW   = 5'd2,
    S_FETCH2   = 5'd3,
    S_DECODE   = 5'd4,
    S_EXEC_R   = 5'd5,
    S_WB_R     = 5'd6,
    S_EXEC_I   = 5'd7,
    S_WB_I     = 5'd8,
    S_MEM_ADDR = 5'd9,
    S_MEM_RD0  = 5'd10,
    S_MEM_RDW  = 5'd11,
    S_WB_LW    = 5'd12,
    S_MEM_WR   = 5'd13,
    S_BRANCH   = 5'd14,
    S_JUMP     = 5'd15,
`ifdef ALU_CTRL_TRAP_EN
    S_ILLEGAL  = 5'd16,
    S_TRAP     = 5'd17
`else
    S_ILLEGAL  = 5'd16
`endif
  } state_e;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SL2 = 2'b11;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_src_ctrl_fsm_alu_funct_decode.sv
// R-type funct to ALU opcode mapper; valid low for unsupported funct codes.
// Purely combinational, zero latency, no flow control.
module alu_funct_decode
  import alu_src_ctrl_fsm_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_vld
);

  always_comb begin
    o_alu_op = ALU_PASS;
    o_vld    = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      default: o_vld    = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_src_ctrl_fsm.sv
// Multicycle fetch/decode/execute sequencer driving ALU operand selects and datapath enables.
// Moore outputs registered with the state; MEM_WAIT stall cycles after each memory read; ALU_CTRL_TRAP_EN adds TRAP.
module alu_src_ctrl_fsm
  import alu_src_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [4:0] state
);

  localparam logic [1:0] WAIT_LAST = (MEM_WAIT == 0) ? 2'd0 : 2'(MEM_WAIT - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_wait_cnt;
  logic [1:0] w_wait_nxt;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl_nxt;
  logic [2:0] w_funct_op;
  logic       w_funct_vld;

  alu_funct_decode u_funct_dec (
    .i_funct  (funct),
    .o_alu_op (w_funct_op),
    .o_vld    (w_funct_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_RST:    w_state_nxt = S_FETCH0;
      S_FETCH0: begin
        if (MEM_WAIT == 0) begin
          w_state_nxt = S_FETCH2;
        end else begin
          w_state_nxt = S_FETCHW;
          w_wait_nxt  = WAIT_LAST;
        end
      end
      S_FETCHW: begin
        if (r_wait_cnt == 2'd0) w_state_nxt = S_FETCH2;
        else                    w_wait_nxt  = r_wait_cnt - 2'd1;
      end
      S_FETCH2: w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_state_nxt = S_EXEC_R;
          OP_ADDI:      w_state_nxt = S_EXEC_I;
          OP_LW, OP_SW: w_state_nxt = S_MEM_ADDR;
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_J:         w_state_nxt = S_JUMP;
          default:      w_state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   w_state_nxt = w_funct_vld ? S_WB_R : S_ILLEGAL;
      S_EXEC_I:   w_state_nxt = S_WB_I;
      S_MEM_ADDR: w_state_nxt = (opcode == OP_LW) ? S_MEM_RD0 : S_MEM_WR;
      S_MEM_RD0: begin
        if (MEM_WAIT == 0) begin
          w_state_nxt = S_WB_LW;
        end else begin
          w_state_nxt = S_MEM_RDW;
          w_wait_nxt  = WAIT_LAST;
        end
      end
      S_MEM_RDW: begin
        if (r_wait_cnt == 2'd0) w_state_nxt = S_WB_LW;
        else                    w_wait_nxt  = r_wait_cnt - 2'd1;
      end
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP:
        w_state_nxt = S_FETCH0;
`ifdef ALU_CTRL_TRAP_EN
      S_ILLEGAL: w_state_nxt = S_TRAP;
      S_TRAP:    w_state_nxt = S_FETCH0;
`else
      S_ILLEGAL: w_state_nxt = S_FETCH0;
`endif
      default:   w_state_nxt = S_RST;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with r_state.
  always_comb begin
    w_ctrl_nxt = '0;
    case (w_state_nxt)
      S_FETCH2: begin
        w_ctrl_nxt.ir_write  = 1'b1;
        w_ctrl_nxt.alu_src_b = SRCB_FOUR;
        w_ctrl_nxt.alu_op    = ALU_ADD;
        w_ctrl_nxt.pc_source = PCSRC_ALU;
        w_ctrl_nxt.pc_write  = 1'b1;
      end
      S_DECODE: begin
        w_ctrl_nxt.ab_write     = 1'b1;
        w_ctrl_nxt.alu_src_b    = SRCB_SEXT_SL2;
        w_ctrl_nxt.alu_op       = ALU_ADD;
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        w_ctrl_nxt.alu_src_a    = 1'b1;
        w_ctrl_nxt.alu_src_b    = SRCB_REG;
        w_ctrl_nxt.alu_op       = w_funct_op;
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_WB_R: begin
        w_ctrl_nxt.reg_dst   = 1'b1;
        w_ctrl_nxt.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        w_ctrl_nxt.alu_src_a    = 1'b1;
        w_ctrl_nxt.alu_src_b    = SRCB_SEXT;
        w_ctrl_nxt.alu_op       = ALU_ADD;
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_WB_I:              w_ctrl_nxt.reg_write = 1'b1;
      S_MEM_RD0, S_MEM_RDW: w_ctrl_nxt.iord     = 1'b1;
      S_WB_LW: begin
        w_ctrl_nxt.mem_to_reg = 1'b1;
        w_ctrl_nxt.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl_nxt.iord      = 1'b1;
        w_ctrl_nxt.mem_write = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl_nxt.alu_src_a = 1'b1;
        w_ctrl_nxt.alu_src_b = SRCB_REG;
        w_ctrl_nxt.alu_op    = ALU_SUB;
        w_ctrl_nxt.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl_nxt.pc_source = PCSRC_JUMP;
        w_ctrl_nxt.pc_write  = 1'b1;
      end
      S_ILLEGAL: w_ctrl_nxt.illegal = 1'b1;
`ifdef ALU_CTRL_TRAP_EN
      S_TRAP: begin
        w_ctrl_nxt.pc_source = PCSRC_TRAP;
        w_ctrl_nxt.pc_write  = 1'b1;
      end
`endif
      default: w_ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RST;
      r_wait_cnt <= 2'd0;
      r_ctrl     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_ctrl     <= w_ctrl_nxt;
    end
  end

  // Branch decision uses the live zero flag, so this one enable is not registered.
  assign pc_write     = r_ctrl.pc_write | ((r_state == S_BRANCH) & zero);
  assign alu_src_a    = r_ctrl.alu_src_a;
  assign alu_src_b    = r_ctrl.alu_src_b;
  assign alu_op       = r_ctrl.alu_op;
  assign pc_source    = r_ctrl.pc_source;
  assign ir_write     = r_ctrl.ir_write;
  assign iord         = r_ctrl.iord;
  assign mem_write    = r_ctrl.mem_write;
  assign ab_write     = r_ctrl.ab_write;
  assign aluout_write = r_ctrl.aluout_write;
  assign reg_write    = r_ctrl.reg_write;
  assign reg_dst      = r_ctrl.reg_dst;
  assign mem_to_reg   = r_ctrl.mem_to_reg;
  assign illegal      = r_ctrl.illegal;
  assign state        = r_state;

endmodule
